udp_tx_arbiter: RTL and testbench

- Shares the single UDP transmit interface (valid/ready plus a wide packet vector and length) between two packet sources: port 0 carries RTP audio, port 1 carries control/status.
- Each grant covers one whole packet and is locked until the downstream UDP stack accepts it.
- Arbitration is round-robin or fixed-priority; a programmable idle gap separates packets.
- Per-source packet counters and a sticky stall flag are provided for debug.

---
 rtl/udp_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_udp_tx_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_arbiter
// Purpose  : Shares one UDP transmit interface between two packet sources with
//            whole-packet grants, round-robin or fixed priority, and idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_arbiter #(
    parameter int DATA_W      = 7680,
    parameter int GAP_CYCLES  = 16,
    parameter int STALL_LIMIT = 65535,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [15:0]       req0_length,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [15:0]       req1_length,
    output logic              udp_send_data_valid,
    input  logic              udp_send_data_ready,
    output logic [DATA_W-1:0] udp_send_data,
    output logic [15:0]       udp_send_data_length,
    output logic              grant_id,
    output logic              busy,
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1,
    output logic              stall_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int c_GAP_W   = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int c_STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [c_GAP_W-1:0]   c_GAP_LOAD   = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

    state_t               r_state;
    logic                 r_grant;
    logic                 r_last;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_stall_err;
    logic [15:0]          r_cnt0;
    logic [15:0]          r_cnt1;

    logic w_send;
    logic w_tie;
    logic w_pick1;

    // On a round-robin tie the port that was not served last wins.
    always_comb begin
        w_tie = req0_valid & req1_valid;
        if (w_tie) begin
            w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end else begin
            w_pick1 = ~req0_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_last      <= 1'b1;
            r_gap_cnt   <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
            r_cnt0      <= 16'd0;
            r_cnt1      <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_valid | req1_valid) begin
                        r_grant     <= w_pick1;
                        r_stall_cnt <= '0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (udp_send_data_ready) begin
                        if (r_grant) begin
                            r_cnt1 <= r_cnt1 + 16'd1;
                        end else begin
                            r_cnt0 <= r_cnt0 + 16'd1;
                        end
                        r_last <= r_grant;
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= c_GAP_LOAD;
                            r_state   <= ST_GAP;
                        end
                    end else if (r_stall_cnt == c_STALL_LAST) begin
                        // Watchdog only flags; the packet stays granted.
                        r_stall_err <= 1'b1;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_send               = (r_state == ST_SEND);
    assign udp_send_data_valid  = w_send;
    assign req0_ready           = w_send & ~r_grant & udp_send_data_ready;
    assign req1_ready           = w_send & r_grant & udp_send_data_ready;
    assign udp_send_data        = w_send ? (r_grant ? req1_data : req0_data) : '0;
    assign udp_send_data_length = w_send ? (r_grant ? req1_length : req0_length) : 16'd0;
    assign grant_id             = r_grant;
    assign busy                 = (r_state != ST_IDLE);
    assign pkt_cnt0             = r_cnt0;
    assign pkt_cnt1             = r_cnt1;
    assign stall_err            = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_arbiter
// Purpose  : Self-checking bench for udp_tx_arbiter (round-robin and fixed
//            priority instances driven by shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_arbiter;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1, rdy;
    logic [DW-1:0] d0, d1;
    logic [15:0]   l0, l1;

    logic          rr_valid, rr_r0, rr_r1, rr_grant, rr_busy, rr_err;
    logic [DW-1:0] rr_data;
    logic [15:0]   rr_len, rr_c0, rr_c1;
    logic          fp_valid, fp_r0, fp_r1, fp_grant, fp_busy, fp_err;
    logic [DW-1:0] fp_data;
    logic [15:0]   fp_len, fp_c0, fp_c1;

    always #5 clk = ~clk;

    udp_tx_arbiter #(.DATA_W(DW), .GAP_CYCLES(16), .STALL_LIMIT(300), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rr_r0), .req0_data(d0), .req0_length(l0),
        .req1_valid(v1), .req1_ready(rr_r1), .req1_data(d1), .req1_length(l1),
        .udp_send_data_valid(rr_valid), .udp_send_data_ready(rdy),
        .udp_send_data(rr_data), .udp_send_data_length(rr_len),
        .grant_id(rr_grant), .busy(rr_busy), .pkt_cnt0(rr_c0), .pkt_cnt1(rr_c1),
        .stall_err(rr_err)
    );

    udp_tx_arbiter #(.DATA_W(DW), .GAP_CYCLES(0), .STALL_LIMIT(1000), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(fp_r0), .req0_data(d0), .req0_length(l0),
        .req1_valid(v1), .req1_ready(fp_r1), .req1_data(d1), .req1_length(l1),
        .udp_send_data_valid(fp_valid), .udp_send_data_ready(rdy),
        .udp_send_data(fp_data), .udp_send_data_length(fp_len),
        .grant_id(fp_grant), .busy(fp_busy), .pkt_cnt0(fp_c0), .pkt_cnt1(fp_c1),
        .stall_err(fp_err)
    );

    // Reference model, one slot per instance: phase 0 idle, -1 sending, >0 gap cycles left
    int          p_gap[2];
    int          p_limit[2];
    bit          p_fixed[2];
    int          m_phase[2];
    int          m_grant[2];
    int          m_last[2];
    int          m_stall[2];
    bit          m_err[2];
    logic [15:0] m_cnt0[2];
    logic [15:0] m_cnt1[2];

    int n_assert = 0;
    int n_fail   = 0;
    int rr_grants[$];
    bit fp_r1_seen;
    bit rr_r1_seen;

    task automatic model_step(input int i);
        if (!rst_n) begin
            m_phase[i] = 0; m_grant[i] = 0; m_last[i] = 1; m_stall[i] = 0;
            m_err[i] = 1'b0; m_cnt0[i] = 16'd0; m_cnt1[i] = 16'd0;
        end else if (m_phase[i] == 0) begin
            if (v0 || v1) begin
                if (v0 && v1) m_grant[i] = p_fixed[i] ? 0 : 1 - m_last[i];
                else          m_grant[i] = v0 ? 0 : 1;
                m_phase[i] = -1;
                m_stall[i] = 0;
            end
        end else if (m_phase[i] < 0) begin
            if (rdy) begin
                if (m_grant[i] == 0) m_cnt0[i] = m_cnt0[i] + 16'd1;
                else                 m_cnt1[i] = m_cnt1[i] + 16'd1;
                m_last[i]  = m_grant[i];
                m_phase[i] = p_gap[i];
            end else begin
                m_stall[i] = m_stall[i] + 1;
                if (m_stall[i] >= p_limit[i]) m_err[i] = 1'b1;
            end
        end else begin
            m_phase[i] = m_phase[i] - 1;
        end
    endtask

    function automatic logic [117:0] exp_vec(input int i);
        logic          snd, g;
        logic [DW-1:0] d;
        logic [15:0]   l;
        snd = (m_phase[i] < 0);
        g   = (m_grant[i] == 1);
        d   = snd ? (g ? d1 : d0) : '0;
        l   = snd ? (g ? l1 : l0) : 16'd0;
        return {snd, snd && !g && rdy, snd && g && rdy, g, m_phase[i] != 0, m_err[i],
                m_cnt0[i], m_cnt1[i], l, d};
    endfunction

    task automatic chk(input string tag, input logic [117:0] obs, input logic [117:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare both instances, then drive the inputs for the next edge.
    task automatic tick(input bit nv0, input bit nv1, input bit nrdy, input bit nrst);
        @(negedge clk);
        chk("rr_outputs", {rr_valid, rr_r0, rr_r1, rr_grant, rr_busy, rr_err, rr_c0, rr_c1, rr_len, rr_data}, exp_vec(0));
        chk("fp_outputs", {fp_valid, fp_r0, fp_r1, fp_grant, fp_busy, fp_err, fp_c0, fp_c1, fp_len, fp_data}, exp_vec(1));
        if (rr_valid && rdy && rst_n) rr_grants.push_back(int'(rr_grant));
        if (fp_r1) fp_r1_seen = 1'b1;
        if (rr_r1) rr_r1_seen = 1'b1;
        if (!nv0 || rr_r0 || fp_r0) begin
            d0 = {$urandom, $urandom};
            l0 = 16'($urandom_range(1, 960));
        end
        if (!nv1 || rr_r1 || fp_r1) begin
            d1 = {$urandom, $urandom};
            l1 = 16'($urandom_range(1, 960));
        end
        v0 = nv0; v1 = nv1; rdy = nrdy; rst_n = nrst;
        model_step(0);
        model_step(1);
    endtask

    initial begin
        p_gap   = '{16, 0};
        p_limit = '{300, 1000};
        p_fixed = '{1'b0, 1'b1};
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
        d0 = '0; d1 = '0; l0 = 16'd0; l1 = 16'd0;
        fp_r1_seen = 1'b0; rr_r1_seen = 1'b0;
        model_step(0);
        model_step(1);

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk1("reset_busy_cnt", {rr_busy, fp_busy, rr_c0[6:0], rr_c1[6:0]}, 16'd0);

        // Port 0 alone, ready high
        repeat (20) tick(1'b1, 1'b0, 1'b1, 1'b1);

        // Both valid continuously after a fresh reset
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rr_grants.delete();
        fp_r1_seen = 1'b0;
        repeat (80) tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk1("rr_grant_count_ge4", 16'(rr_grants.size() >= 4), 16'd1);
        if (rr_grants.size() >= 4) begin
            chk1("rr_grant_seq", 16'({rr_grants[0][0], rr_grants[1][0], rr_grants[2][0], rr_grants[3][0]}), 16'b0101);
        end
        chk1("fp_req1_ready_never", 16'(fp_r1_seen), 16'd0);

        // Stall: ready held low well past the round-robin instance's limit
        repeat (340) tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk1("rr_stall_err_set", 16'(rr_err), 16'd1);
        chk1("fp_stall_err_clear", 16'(fp_err), 16'd0);
        repeat (25) tick(1'b1, 1'b0, 1'b1, 1'b1);
        chk1("rr_stall_err_sticky", 16'(rr_err), 16'd1);

        // Randomized traffic
        repeat (400) tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) < 7, 1'b1);

        // Mid-operation reset while port 1 is granted
        repeat (20) tick(1'b0, 1'b0, 1'b1, 1'b1);
        begin : wait_send
            bit got;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                tick(1'b0, 1'b1, 1'b0, 1'b1);
                got = rr_valid;
            end
            chk1("rr_send_before_reset", 16'(got), 16'd1);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk1("async_reset_outputs", {rr_valid, rr_r1, rr_busy, fp_valid, fp_r1, fp_busy, rr_err, 9'd0}, 16'd0);
        chk1("async_reset_data", rr_data[15:0] | rr_len | fp_data[15:0] | fp_len, 16'd0);
        rr_r1_seen = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b1, 1'b1, 1'b1);
        chk1("rr_req1_after_reset", 16'(rr_r1_seen), 16'd1);
        chk1("rr_cnt1_after_reset", rr_c1, 16'd1);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
